// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: NOP encoding, reset PC default, MIPS field layout
// and the {pc, instr} record carried between the fetch stage and its skid buffer.
package if_stage_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // R-type field layout as decode slices it: op[31:26] rs[25:21] rt[20:16] rd[15:11] shamt[10:6] funct[5:0]
  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_r_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_word_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry holding register for an instruction word that returns from memory
// while decode is stalled; clear wins over load, load wins over drain.
module if_skid_buf
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  fetch_word_t wr_word,
  output fetch_word_t rd_word,
  output logic        vld
);

  fetch_word_t word_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
    end else if (clear) begin
      vld <= 1'b0;
    end else if (load) begin
      vld <= 1'b1;
    end else if (drain) begin
      vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load && !clear) begin
      word_p0 <= wr_word;
    end
  end

  assign rd_word = word_p0;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, synchronous imem request, in-flight tracking,
// skid buffering across stalls and the IF/ID register feeding decode.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               pcwr_en_i,
  input  logic [31:0]        pc_target_i,
  output logic               imem_en_o,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [31:0]        imem_rdata_i,
  output logic [31:0]        pc_o,
  output logic [31:0]        pc4_o,
  output logic [31:0]        instr_o,
  output logic               valid_o
);

  logic [31:0] fetch_pc_p0;
  logic        vld_p1;
  logic [31:0] pc_p1;
  logic        vld_p2;
  logic [31:0] pc_p2;
  logic [31:0] pc4_p2;
  logic [31:0] instr_p2;

  logic        skid_load;
  logic        skid_drain;
  logic        skid_vld;
  fetch_word_t skid_wr;
  fetch_word_t skid_rd;

  // p0: fetch PC and memory request; a redirect fetches even while decode is stalled
  assign imem_en_o   = rst_n & (!stall_i | pcwr_en_i);
  assign imem_addr_o = fetch_pc_p0[IMEM_AW+1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_p0 <= RESET_PC;
    end else if (pcwr_en_i) begin
      fetch_pc_p0 <= word_align(pc_target_i);
    end else if (!stall_i) begin
      fetch_pc_p0 <= fetch_pc_p0 + 32'd4;
    end
  end

  // p1: word in flight in the memory; a redirect squashes it before it lands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= imem_en_o & !pcwr_en_i;
    end
  end

  always_ff @(posedge clk) begin
    if (imem_en_o) begin
      pc_p1 <= fetch_pc_p0;
    end
  end

  // Memory output is not held while disabled, so park the returning word when IF/ID is full
  assign skid_load  = !pcwr_en_i & stall_i & vld_p1 & vld_p2;
  assign skid_drain = !pcwr_en_i & !stall_i & skid_vld;
  assign skid_wr    = '{pc: pc_p1, instr: imem_rdata_i};

  if_skid_buf u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (skid_load),
    .drain   (skid_drain),
    .clear   (pcwr_en_i),
    .wr_word (skid_wr),
    .rd_word (skid_rd),
    .vld     (skid_vld)
  );

  // p2: IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2   <= 1'b0;
      pc_p2    <= 32'd0;
      pc4_p2   <= 32'd0;
      instr_p2 <= NOP_INSTR;
    end else if (pcwr_en_i) begin
      vld_p2   <= 1'b0;
      pc_p2    <= 32'd0;
      pc4_p2   <= 32'd0;
      instr_p2 <= NOP_INSTR;
    end else if (stall_i) begin
      if (!vld_p2 && vld_p1) begin
        vld_p2   <= 1'b1;
        pc_p2    <= pc_p1;
        pc4_p2   <= pc_p1 + 32'd4;
        instr_p2 <= imem_rdata_i;
      end
    end else if (skid_vld) begin
      vld_p2   <= 1'b1;
      pc_p2    <= skid_rd.pc;
      pc4_p2   <= skid_rd.pc + 32'd4;
      instr_p2 <= skid_rd.instr;
    end else if (vld_p1) begin
      vld_p2   <= 1'b1;
      pc_p2    <= pc_p1;
      pc4_p2   <= pc_p1 + 32'd4;
      instr_p2 <= imem_rdata_i;
    end else begin
      vld_p2   <= 1'b0;
      pc_p2    <= 32'd0;
      pc4_p2   <= 32'd0;
      instr_p2 <= NOP_INSTR;
    end
  end

  assign valid_o = vld_p2;
  assign pc_o    = pc_p2;
  assign pc4_o   = pc4_p2;
  assign instr_o = instr_p2;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table from reset release plus a hand-written
// asynchronous-reset-with-skid sequence; memory word i holds 32'h1000_0000 + i.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall_i;
  logic        pcwr_en_i;
  logic [31:0] pc_target_i;
  logic        imem_en_o;
  logic [9:0]  imem_addr_o;
  logic [31:0] imem_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic [31:0] instr_o;
  logic        valid_o;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [1024];

  if_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (10)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .pcwr_en_i    (pcwr_en_i),
    .pc_target_i  (pc_target_i),
    .imem_en_o    (imem_en_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata_i),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .instr_o      (instr_o),
    .valid_o      (valid_o)
  );

  always #5 clk = ~clk;

  // Synchronous memory; output is garbage whenever it was not enabled
  always @(posedge clk) begin
    imem_rdata_i <= imem_en_o ? mem[imem_addr_o] : 32'hDEAD_BEEF;
  end

  typedef struct {
    logic        stall;
    logic        pcwr;
    logic [31:0] tgt;
    logic        en;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic stall, input logic pcwr, input logic [31:0] tgt,
                     input logic en, input logic vld, input logic [31:0] pc,
                     input logic [31:0] instr);
    vec_t v;
    v.stall = stall; v.pcwr = pcwr; v.tgt = tgt;
    v.en = en; v.vld = vld; v.pc = pc; v.instr = instr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic vld, input logic [31:0] pc,
                          input logic [31:0] instr);
    logic [31:0] pc4;
    pc4 = vld ? pc + 32'd4 : 32'd0;
    chk({tag, " valid_o"}, {31'd0, valid_o}, {31'd0, vld});
    chk({tag, " pc_o"}, pc_o, vld ? pc : 32'd0);
    chk({tag, " pc4_o"}, pc4_o, pc4);
    chk({tag, " instr_o"}, instr_o, vld ? instr : 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + i;

    // stall, pcwr, target, exp imem_en, exp valid, exp pc, exp instr (after the edge)
    add(0, 0, 0,            1, 0, 0,            0);
    add(0, 0, 0,            1, 1, 32'h0,        32'h1000_0000);
    add(0, 0, 0,            1, 1, 32'h4,        32'h1000_0001);
    add(0, 0, 0,            1, 1, 32'h8,        32'h1000_0002);
    add(1, 0, 0,            0, 1, 32'h8,        32'h1000_0002);
    add(1, 0, 0,            0, 1, 32'h8,        32'h1000_0002);
    add(1, 0, 0,            0, 1, 32'h8,        32'h1000_0002);
    add(0, 0, 0,            1, 1, 32'hC,        32'h1000_0003);
    add(0, 0, 0,            1, 1, 32'h10,       32'h1000_0004);
    add(0, 1, 32'h103,      1, 0, 0,            0);
    add(0, 0, 0,            1, 0, 0,            0);
    add(0, 0, 0,            1, 1, 32'h100,      32'h1000_0040);
    add(0, 0, 0,            1, 1, 32'h104,      32'h1000_0041);
    add(1, 0, 0,            0, 1, 32'h104,      32'h1000_0041);
    add(1, 1, 32'h40,       1, 0, 0,            0);
    add(1, 0, 0,            0, 0, 0,            0);
    add(0, 0, 0,            1, 0, 0,            0);
    add(0, 0, 0,            1, 1, 32'h40,       32'h1000_0010);
    add(0, 0, 0,            1, 1, 32'h44,       32'h1000_0011);
    add(0, 1, 32'hFFFF_FFFF, 1, 0, 0,           0);
    add(0, 0, 0,            1, 0, 0,            0);
    add(0, 0, 0,            1, 1, 32'hFFFF_FFFC, 32'h1000_03FF);
    add(0, 0, 0,            1, 1, 32'h0,        32'h1000_0000);
    add(0, 0, 0,            1, 1, 32'h4,        32'h1000_0001);
    add(0, 1, 32'h200,      1, 0, 0,            0);
    add(0, 0, 0,            1, 0, 0,            0);
    add(1, 0, 0,            0, 1, 32'h200,      32'h1000_0080);
    add(1, 0, 0,            0, 1, 32'h200,      32'h1000_0080);
    add(0, 0, 0,            1, 0, 0,            0);
    add(0, 0, 0,            1, 1, 32'h204,      32'h1000_0081);

    rst_n = 1'b0; stall_i = 1'b0; pcwr_en_i = 1'b0; pc_target_i = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 32'd0, 32'd0);
    chk("reset imem_en_o", {31'd0, imem_en_o}, 32'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      rst_n       = 1'b1;
      stall_i     = vq[i].stall;
      pcwr_en_i   = vq[i].pcwr;
      pc_target_i = vq[i].tgt;
      #1;
      chk($sformatf("v%0d imem_en_o", i), {31'd0, imem_en_o}, {31'd0, vq[i].en});
      if (i == 0) chk("v0 imem_addr_o", {22'd0, imem_addr_o}, 32'd0);
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vq[i].vld, vq[i].pc, vq[i].instr);
    end

    // Park word 0x208 in the skid, then reset asynchronously mid-cycle
    @(negedge clk);
    stall_i = 1'b1; pcwr_en_i = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("skid hold", 1'b1, 32'h204, 32'h1000_0081);
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("async reset", 1'b0, 32'd0, 32'd0);
    chk("async reset imem_en_o", {31'd0, imem_en_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; stall_i = 1'b0;
    @(posedge clk);
    #1;
    chk_outs("restart e1", 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    chk_outs("restart e2", 1'b1, 32'h0, 32'h1000_0000);
    @(posedge clk);
    #1;
    chk_outs("restart e3", 1'b1, 32'h4, 32'h1000_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
